// File: rtl/reg_seq_pkg.sv
// Shared constants for the register-stack bring-up sequencer: FSM state
// encoding, the four fill base patterns and the used address range.
// REG_SEQ_VERIFY_EN (see reg_stack_sequencer) enables the readback state.
package reg_seq_pkg;

    // FSM state encoding, also presented on the sequencer's state_dbg port.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_VERIFY = 2'd2;
    localparam logic [1:0] ST_SCAN   = 2'd3;

    // Base patterns selected by Mode when a fill starts.
    localparam logic [31:0] PAT_MODE0 = 32'h1234_5678;
    localparam logic [31:0] PAT_MODE1 = 32'hFFFF_FFFF;
    localparam logic [31:0] PAT_MODE2 = 32'hF0F0_F0F0;
    localparam logic [31:0] PAT_MODE3 = 32'h0000_007F;

    // Register 0 is never written or scanned.
    localparam int unsigned FIRST_ADDR = 1;
    localparam int unsigned LAST_ADDR  = 31;

    function automatic logic [31:0] pattern_for_mode(input logic [1:0] mode);
        logic [31:0] p;
        case (mode)
            2'b00:   p = PAT_MODE0;
            2'b01:   p = PAT_MODE1;
            2'b10:   p = PAT_MODE2;
            default: p = PAT_MODE3;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/reg_stack_sequencer_dwell_timer.sv
// dwell_timer: terminal-count counter running 0..CYCLES-1 while enabled.
// tc is high in the enabled cycle that holds the terminal count, so one tc
// pulse occurs every CYCLES enabled cycles. clr forces the count to 0.
module dwell_timer #(
    parameter int unsigned CYCLES = 25_000_000
) (
    input  logic CLK,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign tc = en && (count == CNT_LAST);

    // Count enabled cycles, wrapping to 0 after the terminal count.
    always_ff @(posedge CLK) begin
        if (Reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/reg_stack_sequencer.sv
// reg_stack_sequencer: fills registers 1..31 of the register stack with
// base pattern + address, optionally reads them back (REG_SEQ_VERIFY_EN),
// then scans read port A at the dwell rate for the display path.
//
// Handshake: Start is a single-cycle request accepted only in IDLE or SCAN
// (ignored while Busy); the sequence answers with a one-cycle Done pulse in
// the first SCAN cycle. There is no back-pressure on either side.
module reg_stack_sequencer
    import reg_seq_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DWELL_CYCLES = 25_000_000
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic [1:0]        Mode,
    input  logic              Hold,
    input  logic [DATA_W-1:0] R_Data_A,
    output logic              Write_Reg,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic [ADDR_W-1:0] R_Addr_A,
    output logic [DATA_W-1:0] Disp_Data,
    output logic              Busy,
    output logic              Done,
`ifdef REG_SEQ_VERIFY_EN
    output logic              Err,
`endif
    output logic [1:0]        state_dbg
);

    localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(LAST_ADDR);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] scan_addr;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] addr_word;
    logic [DATA_W-1:0] disp_r;
    logic              done_r;
    logic              scanning;
    logic              dwell_tc;
`ifdef REG_SEQ_VERIFY_EN
    logic              err_r;
`endif

    // Word expected at the current fill/verify address.
    assign addr_word = base + DATA_W'(addr);
    assign scanning  = (state == ST_SCAN);

    dwell_timer #(
        .CYCLES (DWELL_CYCLES)
    ) u_dwell (
        .CLK   (CLK),
        .Reset (Reset),
        .clr   (!scanning),
        .en    (scanning && !Hold),
        .tc    (dwell_tc)
    );

    // Sequencer FSM plus its address, base, display and flag registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= ST_IDLE;
            addr      <= '0;
            scan_addr <= '0;
            base      <= '0;
            disp_r    <= '0;
            done_r    <= 1'b0;
`ifdef REG_SEQ_VERIFY_EN
            err_r     <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        base   <= DATA_W'(pattern_for_mode(Mode));
                        addr   <= ADDR_FIRST;
                        disp_r <= '0;
`ifdef REG_SEQ_VERIFY_EN
                        err_r  <= 1'b0;
`endif
                        state  <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (addr == ADDR_LAST) begin
                        addr <= ADDR_FIRST;
`ifdef REG_SEQ_VERIFY_EN
                        state <= ST_VERIFY;
`else
                        scan_addr <= ADDR_FIRST;
                        done_r    <= 1'b1;
                        state     <= ST_SCAN;
`endif
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
`ifdef REG_SEQ_VERIFY_EN
                ST_VERIFY: begin
                    if (R_Data_A != addr_word) begin
                        err_r <= 1'b1;
                    end
                    if (addr == ADDR_LAST) begin
                        scan_addr <= ADDR_FIRST;
                        done_r    <= 1'b1;
                        state     <= ST_SCAN;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
`endif
                ST_SCAN: begin
                    if (Start) begin
                        base   <= DATA_W'(pattern_for_mode(Mode));
                        addr   <= ADDR_FIRST;
                        disp_r <= '0;
`ifdef REG_SEQ_VERIFY_EN
                        err_r  <= 1'b0;
`endif
                        state  <= ST_FILL;
                    end else begin
                        disp_r <= R_Data_A;
                        if (dwell_tc) begin
                            scan_addr <= (scan_addr == ADDR_LAST) ? ADDR_FIRST
                                                                  : scan_addr + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Register-stack ports decoded from the current state.
    always_comb begin
        Write_Reg = 1'b0;
        W_Addr    = '0;
        W_Data    = '0;
        R_Addr_A  = '0;
        case (state)
            ST_FILL: begin
                Write_Reg = 1'b1;
                W_Addr    = addr;
                W_Data    = addr_word;
            end
            ST_VERIFY: R_Addr_A = addr;
            ST_SCAN:   R_Addr_A = scan_addr;
            default:   ;
        endcase
    end

    assign Busy      = (state == ST_FILL) || (state == ST_VERIFY);
    assign Done      = done_r;
    assign Disp_Data = disp_r;
    assign state_dbg = state;
`ifdef REG_SEQ_VERIFY_EN
    assign Err       = err_r;
`endif

endmodule

// File: tb/tb_reg_stack_sequencer.sv
// Self-checking bench for reg_stack_sequencer with a behavioural register
// stack. Expected writes, Done cycles and Busy lengths are queued when a
// fill is issued; a negedge monitor pops and compares them, and checks the
// scan address walk, dwell timing and display data against the fill rules.
`timescale 1ns/1ps
module tb_reg_stack_sequencer;

    localparam int DWELL = 4;
`ifdef REG_SEQ_VERIFY_EN
    localparam int LAT = 62;
`else
    localparam int LAT = 31;
`endif

    // ---------------- clock / reset ----------------
    logic        CLK   = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  Mode  = 2'b00;
    logic        Hold  = 1'b0;
    logic [31:0] R_Data_A;
    logic        Write_Reg;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic [4:0]  R_Addr_A;
    logic [31:0] Disp_Data;
    logic        Busy;
    logic        Done;
    logic [1:0]  state_dbg;
`ifdef REG_SEQ_VERIFY_EN
    logic        Err;
`endif

    int cyc = 0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    reg_stack_sequencer #(
        .DATA_W       (32),
        .ADDR_W       (5),
        .DWELL_CYCLES (DWELL)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Start     (Start),
        .Mode      (Mode),
        .Hold      (Hold),
        .R_Data_A  (R_Data_A),
        .Write_Reg (Write_Reg),
        .W_Addr    (W_Addr),
        .W_Data    (W_Data),
        .R_Addr_A  (R_Addr_A),
        .Disp_Data (Disp_Data),
        .Busy      (Busy),
        .Done      (Done),
`ifdef REG_SEQ_VERIFY_EN
        .Err       (Err),
`endif
        .state_dbg (state_dbg)
    );

    // ---------------- register stack model ----------------
    logic [31:0] stack [32];
    logic        corrupt7 = 1'b0;
    initial for (int i = 0; i < 32; i++) stack[i] = 32'd0;
    always @(posedge CLK) if (Write_Reg && W_Addr != 5'd0) stack[W_Addr] <= W_Data;
    assign R_Data_A = (corrupt7 && R_Addr_A == 5'd7) ? (stack[7] ^ 32'h1) : stack[R_Addr_A];

    // ---------------- scoreboard state ----------------
    int          n_total = 0;
    int          n_pass  = 0;
    logic [36:0] exp_wr_q[$];
    int          exp_done_q[$];
    int          exp_busy_q[$];
    logic [31:0] cur_base = 32'd0;
    logic        exp_err  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] pat(input logic [1:0] m);
        case (m)
            2'b00:   return 32'h12345678;
            2'b01:   return 32'hFFFFFFFF;
            2'b10:   return 32'hF0F0F0F0;
            default: return 32'h0000007F;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [4:0] a);
        logic [31:0] w;
        w = cur_base + {27'd0, a};
        if (corrupt7 && a == 5'd7) w = w ^ 32'h1;
        return w;
    endfunction

    // ---------------- monitor ----------------
    int         busy_run  = 0;
    int         dwell_run = 0;
    logic       in_scan;
    logic       prev_in_scan = 1'b0;
    logic [4:0] prev_addr    = 5'd0;

    always @(negedge CLK) begin
        if (Write_Reg) begin
            if (exp_wr_q.size() == 0) check("write_unexpected", 64'(Write_Reg), 64'd0);
            else check("write", 64'({W_Addr, W_Data}), 64'(exp_wr_q.pop_front()));
        end
        if (Busy) busy_run++;
        else if (busy_run != 0) begin
            if (exp_busy_q.size() == 0) check("busy_unexpected", 64'(busy_run), 64'd0);
            else check("busy_len", 64'(busy_run), 64'(exp_busy_q.pop_front()));
            busy_run = 0;
        end
        if (Done) begin
            if (exp_done_q.size() == 0) check("done_unexpected", 64'(Done), 64'd0);
            else check("done_cycle", 64'(cyc), 64'(exp_done_q.pop_front()));
        end
        in_scan = !Busy && (R_Addr_A != 5'd0);
        if (in_scan) begin
            if (!prev_in_scan) begin
                check("scan_entry", 64'(R_Addr_A), 64'd1);
                dwell_run = 0;
            end else begin
                check("disp", 64'(Disp_Data), 64'(exp_word(prev_addr)));
                if (R_Addr_A != prev_addr) begin
                    check("scan_next", 64'(R_Addr_A), (prev_addr == 5'd31) ? 64'd1 : 64'(prev_addr) + 64'd1);
                    check("dwell", 64'(dwell_run), 64'(DWELL));
                    dwell_run = 0;
                end else if (dwell_run >= DWELL) begin
                    check("scan_stall", 64'(R_Addr_A), (prev_addr == 5'd31) ? 64'd1 : 64'(prev_addr) + 64'd1);
                end
            end
            if (!Hold) dwell_run++;
`ifdef REG_SEQ_VERIFY_EN
            check("err_scan", 64'(Err), 64'(exp_err));
`endif
        end else begin
            dwell_run = 0;
            check("disp_zero", 64'(Disp_Data), 64'd0);
`ifdef REG_SEQ_VERIFY_EN
            if (Write_Reg) check("err_fill", 64'(Err), 64'd0);
`endif
        end
        prev_in_scan = in_scan;
        prev_addr    = R_Addr_A;
    end

    // ---------------- driver tasks ----------------
    task automatic check_idle(input string tag);
        check({tag, "_wreg"},  64'(Write_Reg), 64'd0);
        check({tag, "_waddr"}, 64'(W_Addr),    64'd0);
        check({tag, "_wdata"}, 64'(W_Data),    64'd0);
        check({tag, "_raddr"}, 64'(R_Addr_A),  64'd0);
        check({tag, "_disp"},  64'(Disp_Data), 64'd0);
        check({tag, "_busy"},  64'(Busy),      64'd0);
        check({tag, "_done"},  64'(Done),      64'd0);
        check({tag, "_state"}, 64'(state_dbg), 64'd0);
`ifdef REG_SEQ_VERIFY_EN
        check({tag, "_err"},   64'(Err),       64'd0);
`endif
    endtask

    // Issue an accepted Start and queue its expected responses. Returns in
    // the first FILL cycle.
    task automatic do_fill(input logic [1:0] mode, input logic corrupt);
        int c;
        @(posedge CLK); #1;
        Start = 1'b1;
        Mode  = mode;
        c     = cyc;
        for (int a = 1; a <= 31; a++) exp_wr_q.push_back({5'(a), pat(mode) + 32'(a)});
        exp_done_q.push_back(c + 1 + LAT);
        exp_busy_q.push_back(LAT);
        @(posedge CLK); #1;
        Start    = 1'b0;
        Mode     = 2'($urandom_range(0, 3));
        cur_base = pat(mode);
        corrupt7 = corrupt;
        exp_err  = corrupt;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge CLK);
            if (Done) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'd1);
    endtask

    task automatic run_scan(input int n, input int hold_pct);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            Hold = ($urandom_range(0, 99) < hold_pct);
        end
        @(posedge CLK); #1;
        Hold = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Reset = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_idle("reset");
        Reset = 1'b0;

        // Mode 00 fill with an ignored Start in the middle of FILL.
        do_fill(2'b00, 1'b0);
        repeat (4) @(posedge CLK);
        #1; Start = 1'b1; Mode = 2'b11;
        @(posedge CLK);
        #1; Start = 1'b0;
        wait_done();
        check("m0_reg1",  64'(stack[1]),  64'h12345679);
        check("m0_reg31", 64'(stack[31]), 64'h12345697);
        run_scan(40, 0);
        Hold = 1'b1;
        repeat (10) @(posedge CLK);
        #1; Hold = 1'b0;
        run_scan(100, 20);

        // Mode 01 refill from SCAN: base + 1 wraps to zero.
        do_fill(2'b01, 1'b0);
        wait_done();
        check("m1_reg1",  64'(stack[1]),  64'h00000000);
        check("m1_reg31", 64'(stack[31]), 64'h0000001E);
        run_scan(60, 30);

        // Mode 10 fill; with readback, register 7 reads back corrupted.
`ifdef REG_SEQ_VERIFY_EN
        do_fill(2'b10, 1'b1);
        wait_done();
        run_scan(20, 10);
        check("err_set", 64'(Err), 64'd1);
`else
        do_fill(2'b10, 1'b0);
        wait_done();
        run_scan(20, 10);
`endif
        check("m2_reg7", 64'(stack[7]), 64'hF0F0F0F7);

        // Mode 11 refill from SCAN clears Err and zeroes the display.
        do_fill(2'b11, 1'b0);
`ifdef REG_SEQ_VERIFY_EN
        check("err_cleared", 64'(Err), 64'd0);
`endif
        check("restart_disp", 64'(Disp_Data), 64'd0);
        wait_done();
        check("m3_reg1", 64'(stack[1]), 64'h00000080);
        run_scan(30, 10);

        // Reset during the 10th write of a mode 00 fill.
        do_fill(2'b00, 1'b0);
        repeat (9) @(posedge CLK);
        #1; Reset = 1'b1;
        @(posedge CLK);
        #1; Reset = 1'b0;
        exp_wr_q.delete();
        exp_done_q.delete();
        exp_busy_q.delete();
        exp_busy_q.push_back(10);
        exp_err = 1'b0;
        check_idle("rst_mid");
        check("rst_reg10", 64'(stack[10]), 64'h12345682);
        check("rst_reg11", 64'(stack[11]), 64'h0000008A);
        repeat (3) @(posedge CLK);
        #1; check("rst_stays_idle", 64'(Write_Reg), 64'd0);

        // Random fill from IDLE followed by a randomized scan.
        do_fill(2'($urandom_range(0, 3)), 1'b0);
        wait_done();
        run_scan(60, 25);

        check("wr_q_empty",   64'(exp_wr_q.size()),   64'd0);
        check("done_q_empty", 64'(exp_done_q.size()), 64'd0);
        check("busy_q_empty", 64'(exp_busy_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
